// File: rtl/arb_mux_pkg.sv
// Shared constants and the rotated round-robin grant function for the N:1 arbitrated mux.
package arb_mux_pkg;

    localparam int WIDTH_MIN    = 1;
    localparam int WIDTH_MAX    = 64;
    localparam int N_INPUTS_MIN = 2;
    localparam int N_INPUTS_MAX = 16;
    localparam int SEL_W_MAX    = $clog2(N_INPUTS_MAX);

    // First set request at or above ptr, wrapping at n-1 -> 0; one-hot or zero.
    function automatic logic [N_INPUTS_MAX-1:0] rr_grant(
        input logic [N_INPUTS_MAX-1:0] req,
        input logic [SEL_W_MAX-1:0]    ptr,
        input int                      n
    );
        logic [N_INPUTS_MAX-1:0] g;
        logic                    found;
        logic [SEL_W_MAX-1:0]    pos;
        int                      c;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N_INPUTS_MAX; k++) begin
            c   = (int'(ptr) + k) % n;
            pos = SEL_W_MAX'(c);
            if (k < n && !found && req[pos]) begin
                g[pos] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, searching upward from ptr.
// Latency: combinational, no state.
// Backpressure: enable low forces grant and index to zero.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [SEL_W-1:0] idx
);

    assign grant = enable ? N'(rr_grant(N_INPUTS_MAX'(req), SEL_W_MAX'(ptr), N)) : '0;

    // Grant is one-hot, so OR-ing the indices of set bits encodes it without priority.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) idx = idx | SEL_W'(i);
        end
    end

endmodule

// File: rtl/arb_mux_n_1.sv
// N:1 round-robin arbitrated mux feeding a single registered output stage.
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle sustained.
// Backpressure: out_ready low with a held beat stalls all inputs (in_ready all-zero).
module arb_mux_n_1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_INPUTS-1:0]       in_valid,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    output logic [N_INPUTS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    input  logic                      out_ready
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("arb_mux_n_1: WIDTH out of range 1..64");
    end
    if (N_INPUTS < N_INPUTS_MIN || N_INPUTS > N_INPUTS_MAX) begin : g_bad_n_inputs
        $error("arb_mux_n_1: N_INPUTS out of range 2..16");
    end
    if (SEL_W != $clog2(N_INPUTS)) begin : g_bad_sel_w
        $error("arb_mux_n_1: SEL_W must equal clog2(N_INPUTS)");
    end

    logic                open;
    logic [N_INPUTS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    ptr;
    logic                xfer;
    logic [WIDTH-1:0]    mux_data;

    assign open = ~out_valid | out_ready;

    // rst_n gates the enable so nothing is accepted while reset is held.
    rr_arbiter #(
        .N     (N_INPUTS),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req    (in_valid),
        .ptr    (ptr),
        .enable (open & rst_n),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign in_ready = grant;
    assign xfer     = |grant;

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (open) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_sel   <= grant_idx;
                ptr       <= (grant_idx == SEL_W'(N_INPUTS-1)) ? '0 : grant_idx + SEL_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/arb_mux_n_1.md
ARB_MUX_N_1 -- requirements
Module: arb_mux_n_1

Interface
REQ-001 Parameter WIDTH, default 4: data bits per input channel; legal 1..64.
REQ-002 Parameter N_INPUTS, default 4: number of input channels; legal 2..16.
REQ-003 Parameter SEL_W, default $clog2(N_INPUTS): width of channel index; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  N_INPUTS  per-channel request; bit i qualifies channel i.
REQ-007 in_data  input  N_INPUTS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
REQ-008 in_ready  output  N_INPUTS  per-channel accept, one-hot or zero.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  WIDTH  registered data of the selected channel.
REQ-011 out_sel  output  SEL_W  index of the channel that supplied out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 A transfer on channel i SHALL occur in a cycle where in_valid[i] & in_ready[i] = 1; an output transfer where out_valid & out_ready = 1.
REQ-014 Output register SHALL be loadable ("open") when out_valid = 0 or out_ready = 1.
REQ-015 Round-robin arbiter SHALL grant exactly one requesting channel per cycle, searching from index ptr upward with wrap N_INPUTS-1 -> 0.
REQ-016 in_ready[i] SHALL equal grant[i] & open; in_ready is combinational from in_valid, ptr, out_valid, out_ready.
REQ-017 On a channel-i transfer, out_data SHALL load in_data channel i, out_sel SHALL load i, out_valid SHALL be 1 next cycle; latency exactly 1 cycle.
REQ-018 When open and no in_valid bit set, out_valid SHALL go 0 next cycle; out_data and out_sel SHALL hold.
REQ-019 When not open, out_valid, out_data, out_sel SHALL hold and in_ready SHALL be all-zero.
REQ-020 ptr SHALL update to (granted index + 1) mod N_INPUTS only on a channel transfer; otherwise hold.
REQ-021 Output drain and new load in same cycle SHALL both occur: sustained throughput one beat per cycle.
REQ-022 Data selection SHALL be AND/OR masking of each channel by its replicated grant bit, ORed across channels; no priority-encoded chain on the data path.
REQ-023 Requester dropping in_valid before transfer SHALL be legal; arbiter re-evaluates every cycle without penalty.

Reset
REQ-024 rst_n = 0 SHALL immediately force out_valid = 0, out_data = 0, out_sel = 0, ptr = 0, independent of clk.
REQ-025 in_ready SHALL be all-zero while rst_n = 0.
REQ-026 Reset mid-transfer SHALL discard the held beat; first post-reset grant SHALL search from channel 0.

Structure
REQ-027 Package arb_mux_pkg SHALL hold legal-range constants for WIDTH/N_INPUTS and the function computing the rotated one-hot grant.
REQ-028 Sub-module rr_arbiter (request vector, ptr, enable -> one-hot grant, encoded index) SHALL be the single instantiated child; datapath and output register stay in arb_mux_n_1.
REQ-029 Parameter-range violations SHALL be caught by elaboration-time assertions.

Verification (N_INPUTS=4, WIDTH=8)
REQ-030 rst_n low mid-stream with out_valid=1, out_data=8'hA5 -> outputs 0 asynchronously; after release, requests on ch 2,3 -> ch 2 granted first.
REQ-031 in_valid=4'b1111, data 8'h10/11/12/13, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data matching, no bubbles.
REQ-032 out_valid=1, out_ready=0 for 5 cycles with all in_valid set -> in_ready=0, out_data/out_sel constant; out_ready=1 -> next beat loaded same cycle.
REQ-033 Only ch 2 valid, out_ready=1 for 6 cycles -> ch 2 granted every cycle, in_ready=4'b0100.
REQ-034 Last grant ch 3 (ptr=0), in_valid=4'b1001 -> ch 0 granted, then ch 3 (wrap check).
REQ-035 in_valid=0 for 3 cycles after a beat drains -> out_valid=0, out_data holds last value.
